// File: rtl/video_gate_pkg.sv
// Shared types and default widths for the video stream gate.
package video_gate_pkg;

   localparam int unsigned DATA_W_DEF = 96;
   localparam int unsigned FCNT_W_DEF = 12;
   localparam int unsigned DROP_W     = 30;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      RUN   = 2'd2
   } gate_state_e;

endpackage : video_gate_pkg

// File: rtl/video_stream_gate.sv
// Frame-aligned gate on an AXI4-Stream video path: forwards whole frames between
// Start and Stop/limit, drops everything else with tready held high.
module video_stream_gate
   import video_gate_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned FCNT_W = FCNT_W_DEF
) (
   input  logic              s_axis_video_aclk,
   input  logic              s_axis_video_aresetn,
   input  logic [DATA_W-1:0] VIDEO_IN_tdata,
   input  logic              VIDEO_IN_tlast,
   input  logic              VIDEO_IN_tuser,
   input  logic              VIDEO_IN_tvalid,
   output logic              VIDEO_IN_tready,
   output logic [DATA_W-1:0] VIDEO_OUT_tdata,
   output logic              VIDEO_OUT_tlast,
   output logic              VIDEO_OUT_tuser,
   output logic              VIDEO_OUT_tvalid,
   input  logic              VIDEO_OUT_tready,
   input  logic              Start,
   input  logic              Stop,
   input  logic [FCNT_W-1:0] FrameLimit,
   output logic              Busy,
   output logic [FCNT_W-1:0] FramesDone,
   output logic [DROP_W-1:0] DroppedBeats
);

   gate_state_e       state;
   logic              stop_pending;
   logic              hold_r;
   logic [FCNT_W-1:0] limit_r;
   logic [FCNT_W-1:0] frames_r;
   logic [DROP_W-1:0] dropped_r;

   logic limit_hit_c;
   logic fwd_dec_c;
   logic fwd_c;
   logic fwd_hs_c;
   logic drop_c;

   // Forward/drop decision; hold_r pins a stalled forward until its handshake.
   always_comb begin
      limit_hit_c = (limit_r != '0) && (frames_r == limit_r);
      fwd_dec_c   = 1'b0;
      case (state)
         IDLE:    fwd_dec_c = 1'b0;
         ARMED:   fwd_dec_c = VIDEO_IN_tuser;
         RUN:     fwd_dec_c = !VIDEO_IN_tuser || !(stop_pending || limit_hit_c);
         default: fwd_dec_c = 1'b0;
      endcase
      fwd_c = hold_r | fwd_dec_c;
   end

   assign VIDEO_OUT_tdata  = VIDEO_IN_tdata;
   assign VIDEO_OUT_tlast  = VIDEO_IN_tlast;
   assign VIDEO_OUT_tuser  = VIDEO_IN_tuser;
   assign VIDEO_OUT_tvalid = VIDEO_IN_tvalid & fwd_c;
   assign VIDEO_IN_tready  = fwd_c ? VIDEO_OUT_tready : 1'b1;

   assign fwd_hs_c = VIDEO_OUT_tvalid & VIDEO_OUT_tready;
   assign drop_c   = VIDEO_IN_tvalid & !fwd_c;

   assign Busy         = (state != IDLE);
   assign FramesDone   = frames_r;
   assign DroppedBeats = dropped_r;

   always_ff @(posedge s_axis_video_aclk or negedge s_axis_video_aresetn) begin
      if (!s_axis_video_aresetn) begin
         state        <= IDLE;
         stop_pending <= 1'b0;
         hold_r       <= 1'b0;
         limit_r      <= '0;
         frames_r     <= '0;
         dropped_r    <= '0;
      end else begin
         hold_r <= VIDEO_OUT_tvalid & ~VIDEO_OUT_tready;

         if (drop_c && (dropped_r != '1)) begin
            dropped_r <= dropped_r + DROP_W'(1);
         end

         case (state)
            IDLE: begin
               if (Start && !Stop) begin
                  state        <= ARMED;
                  frames_r     <= '0;
                  limit_r      <= FrameLimit;
                  stop_pending <= 1'b0;
               end
            end
            ARMED: begin
               // A Stop cannot abandon an SOF already offered downstream.
               if (fwd_hs_c && VIDEO_IN_tuser) begin
                  state    <= RUN;
                  frames_r <= FCNT_W'(1);
               end else if (Stop && !VIDEO_OUT_tvalid) begin
                  state <= IDLE;
               end
            end
            RUN: begin
               if (drop_c && VIDEO_IN_tuser) begin
                  state        <= IDLE;
                  stop_pending <= 1'b0;
               end else begin
                  if (Stop) begin
                     stop_pending <= 1'b1;
                  end
                  if (fwd_hs_c && VIDEO_IN_tuser) begin
                     frames_r <= frames_r + FCNT_W'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule : video_stream_gate

// File: doc/video_stream_gate.md
VIDEO_STREAM_GATE -- requirements
Module: video_stream_gate

Interface
REQ-001 SHALL have parameter DATA_W, default 96, meaning video beat width in bits.
REQ-002 SHALL have parameter FCNT_W, default 12, meaning frame-counter and frame-limit width.
REQ-003 SHALL have port s_axis_video_aclk, input, 1 bit: the single clock, all logic on its rising edge.
REQ-004 SHALL have port s_axis_video_aresetn, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have ports VIDEO_IN_tdata [DATA_W], tlast, tuser, tvalid (inputs) and VIDEO_IN_tready (output): upstream AXI4-Stream video, where tuser is start-of-frame (SOF).
REQ-006 SHALL have ports VIDEO_OUT_tdata [DATA_W], tlast, tuser, tvalid (outputs) and VIDEO_OUT_tready (input): downstream stream.
REQ-007 SHALL have port Start, input, 1 bit: single-cycle request to arm the gate.
REQ-008 SHALL have port Stop, input, 1 bit: single-cycle request to close the gate at the next frame boundary.
REQ-009 SHALL have port FrameLimit, input, FCNT_W bits: frames to pass per run, where 0 means unlimited.
REQ-010 SHALL have port Busy, output, 1 bit: high when state is not IDLE.
REQ-011 SHALL have port FramesDone, output, FCNT_W bits: SOF beats forwarded in the current or last run.
REQ-012 SHALL have port DroppedBeats, output, 30 bits: input beats consumed and not forwarded, saturating.

Function
REQ-013 SHALL pass tdata, tlast and tuser combinationally from input to output, with zero latency and no storage.
REQ-014 SHALL implement states IDLE, ARMED and RUN.
REQ-015 IDLE: SHALL drive VIDEO_IN_tready=1 and VIDEO_OUT_tvalid=0, dropping every input beat.
REQ-016 IDLE: Start SHALL move to ARMED, clear FramesDone and sample FrameLimit into limit_r.
REQ-017 IDLE: Start and Stop in the same cycle SHALL be ignored and the state SHALL stay IDLE.
REQ-018 ARMED: non-SOF beats SHALL be dropped with tready=1 and tvalid=0.
REQ-019 ARMED: an SOF beat SHALL be forwarded (OUT_tvalid=IN_tvalid, IN_tready=OUT_tready); on its handshake the state SHALL move to RUN and FramesDone SHALL become 1.
REQ-020 ARMED: Stop SHALL return to IDLE on the next edge, unless an SOF beat is being offered downstream, in which case REQ-024 applies.
REQ-021 RUN: non-SOF beats SHALL be forwarded (OUT_tvalid=IN_tvalid, IN_tready=OUT_tready).
REQ-022 RUN: Stop SHALL set stop_pending. Start in ARMED or RUN SHALL be ignored.
REQ-023 RUN, SOF beat: if stop_pending=1 or (limit_r≠0 and FramesDone==limit_r), the beat SHALL be dropped with tready=1, the state SHALL go to IDLE and stop_pending SHALL be cleared; otherwise the beat SHALL be forwarded and FramesDone incremented on handshake.
REQ-024 The forward/drop decision for a beat SHALL be latched while it is offered with OUT_tvalid=1 and OUT_tready=0, so that OUT_tvalid never deasserts before handshake.
REQ-025 FramesDone SHALL wrap modulo 2^FCNT_W when limit_r=0.
REQ-026 DroppedBeats SHALL increment on every dropped beat (IN_tvalid & IN_tready & !OUT_tvalid) and hold at 2^30−1.
REQ-027 DroppedBeats SHALL be cleared only by reset.
REQ-028 A lone tlast SHALL NOT affect state; frame boundaries are SOF-defined only.

Reset
REQ-029 Asserting aresetn low SHALL immediately force IDLE, stop_pending=0, limit_r=0, FramesDone=0, DroppedBeats=0, Busy=0, VIDEO_OUT_tvalid=0 and VIDEO_IN_tready=1, including mid-frame.
REQ-030 Reset deassertion SHALL take effect synchronously to s_axis_video_aclk.

Structure
REQ-031 Package video_gate_pkg SHALL hold the state enum (IDLE, ARMED, RUN), DATA_W_DEF=96, FCNT_W_DEF=12 and DROP_W=30.
REQ-032 SHALL be implemented flat with no sub-module; all handshake muxing SHALL be combinational from the state, the latch of REQ-024 and the input flags.

Verification
REQ-033 Reset, then 3 frames of 4 lines × 8 beats with FrameLimit=0 and no Start -> nothing forwarded, DroppedBeats=96, Busy=0.
REQ-034 Start mid-frame, FrameLimit=2 -> remainder of that frame dropped, exactly 2 full frames forwarded, 3rd SOF dropped, IDLE, FramesDone=2.
REQ-035 Stop pulsed in RUN during line 2 -> current frame completes, next SOF dropped, Busy falls the cycle after that SOF's handshake.
REQ-036 SOF offered with OUT_tready=0 for 5 cycles while Stop pulses in ARMED -> OUT_tvalid stays 1 until handshake, then RUN and FramesDone=1.
REQ-037 aresetn pulsed low mid-line in RUN -> outputs reach reset values without a clock edge; the next Start re-arms from a clean state.
REQ-038 Random OUT_tready backpressure over 10 frames, FrameLimit=0 -> forwarded stream bit-identical to input from the first SOF after Start, no valid retraction.
